display_clocks_drp: RTL

Runtime-reconfigurable successor to the fixed-ratio display clock generator. It drives the MMCM dynamic reconfiguration port (DRP) so that one MMCM can switch between NUM_MODES display timings (for example 25.2/126, 74.25/371.25 and 148.5/742.5 MHz) without a new bitstream. It sits between the display mode-select logic and the MMCME2_ADV instance. It holds the MMCM in reset during reprogramming and reports lock once the new clocks are stable.

---
 rtl/display_clocks_drp.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/display_clocks_drp.sv
// rtl/display_clocks_drp.sv - MMCM DRP sequencer that reprograms display clock modes at runtime
// Optional readback verify of every DRP write: define DISPLAY_CLOCKS_DRP_READBACK_EN.
module display_clocks_drp #(
   parameter int NUM_MODES     = 4,
   parameter int MODE_W        = 2,
   parameter int REGS_PER_MODE = 23,
   parameter int DEFAULT_MODE  = 0,
   parameter int LOCK_TIMEOUT  = 2**20,
   // Entry e occupies TABLE[e*40 +: 40]: [38:32] addr, [31:16] keep-mask, [15:0] data
   parameter logic [NUM_MODES*REGS_PER_MODE*40-1:0] TABLE = '0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [MODE_W-1:0] i_mode,
   input  logic              i_mode_req,
   output logic              o_busy,
   output logic [MODE_W-1:0] o_mode,
   output logic              o_err,
   output logic [6:0]        o_drp_addr,
   output logic [15:0]       o_drp_di,
   output logic              o_drp_en,
   output logic              o_drp_we,
   input  logic [15:0]       i_drp_do,
   input  logic              i_drp_rdy,
   output logic              o_mmcm_rst,
   input  logic              i_mmcm_locked,
   output logic              o_locked
);

   localparam int TBL_N = NUM_MODES * REGS_PER_MODE;
   localparam int TA_W  = (TBL_N > 1) ? $clog2(TBL_N) : 1;
   localparam int IDX_W = (REGS_PER_MODE > 1) ? $clog2(REGS_PER_MODE) : 1;
   localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

   localparam logic [MODE_W:0]   MODES_LIM = (MODE_W + 1)'(NUM_MODES);
   localparam logic [MODE_W-1:0] DEF_MODE  = MODE_W'(DEFAULT_MODE);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(REGS_PER_MODE - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LOCK_TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_START,
      S_FETCH,
      S_READ,
      S_READ_WAIT,
      S_WRITE,
      S_WRITE_WAIT,
      S_NEXT,
      S_LOCK_WAIT
`ifdef DISPLAY_CLOCKS_DRP_READBACK_EN
      , S_VERIFY,
      S_VERIFY_WAIT
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [MODE_W-1:0] target_q, target_d;
   logic [MODE_W-1:0] mode_q, mode_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [38:0]       entry_q, entry_d;
   logic [15:0]       di_q, di_d;
   logic              drp_en_q, drp_en_d;
   logic              drp_we_q, drp_we_d;
   logic              mmcm_rst_q, mmcm_rst_d;
   logic              busy_q, busy_d;
   logic              locked_q, locked_d;
   logic              err_q, err_d;
   logic              abort_q, abort_d;

   logic [38:0]       rom [TBL_N];
   logic [TA_W-1:0]   rom_idx;

   for (genvar e = 0; e < TBL_N; e++) begin : g_rom
      assign rom[e] = TABLE[e*40 +: 39];
   end

   assign rom_idx = TA_W'(target_q) * TA_W'(REGS_PER_MODE) + TA_W'(idx_q);

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      mode_d   = mode_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      entry_d  = entry_q;
      di_d     = di_q;
      err_d    = err_q;
      abort_d  = abort_q;

      case (state_q)
         S_IDLE: begin
            if (i_mode_req) begin
               if ({1'b0, i_mode} < MODES_LIM) begin
                  err_d    = 1'b0;
                  target_d = i_mode;
                  state_d  = S_START;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_START: begin
            idx_d   = '0;
            abort_d = 1'b0;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            entry_d = rom[rom_idx];
            state_d = S_READ;
         end
         S_READ: state_d = S_READ_WAIT;
         S_READ_WAIT: begin
            if (i_drp_rdy) begin
               // Bits set in the keep-mask survive from the live register value
               di_d    = (i_drp_do & entry_q[31:16]) | (entry_q[15:0] & ~entry_q[31:16]);
               state_d = S_WRITE;
            end
         end
         S_WRITE: state_d = S_WRITE_WAIT;
         S_WRITE_WAIT: begin
            if (i_drp_rdy) begin
`ifdef DISPLAY_CLOCKS_DRP_READBACK_EN
               state_d = S_VERIFY;
`else
               state_d = S_NEXT;
`endif
            end
         end
`ifdef DISPLAY_CLOCKS_DRP_READBACK_EN
         S_VERIFY: state_d = S_VERIFY_WAIT;
         S_VERIFY_WAIT: begin
            if (i_drp_rdy) begin
               if (i_drp_do != di_q) begin
                  err_d   = 1'b1;
                  abort_d = 1'b1;
                  cnt_d   = '0;
                  state_d = S_LOCK_WAIT;
               end else begin
                  state_d = S_NEXT;
               end
            end
         end
`endif
         S_NEXT: begin
            if (idx_q == LAST_IDX) begin
               cnt_d   = '0;
               state_d = S_LOCK_WAIT;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = S_FETCH;
            end
         end
         S_LOCK_WAIT: begin
            if (i_mmcm_locked) begin
               if (!abort_q) begin
                  mode_d = target_q;
               end
               state_d = S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next state so they line up with state_q
`ifdef DISPLAY_CLOCKS_DRP_READBACK_EN
      drp_en_d = (state_d == S_READ) || (state_d == S_WRITE) || (state_d == S_VERIFY);
`else
      drp_en_d = (state_d == S_READ) || (state_d == S_WRITE);
`endif
      drp_we_d   = (state_d == S_WRITE);
      mmcm_rst_d = (state_d != S_IDLE) && (state_d != S_LOCK_WAIT);
      busy_d     = (state_d != S_IDLE);
      locked_d   = (state_d == S_IDLE) && i_mmcm_locked;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= S_START;
         target_q   <= DEF_MODE;
         mode_q     <= DEF_MODE;
         idx_q      <= '0;
         cnt_q      <= '0;
         entry_q    <= '0;
         di_q       <= '0;
         drp_en_q   <= 1'b0;
         drp_we_q   <= 1'b0;
         mmcm_rst_q <= 1'b1;
         busy_q     <= 1'b1;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         target_q   <= target_d;
         mode_q     <= mode_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         entry_q    <= entry_d;
         di_q       <= di_d;
         drp_en_q   <= drp_en_d;
         drp_we_q   <= drp_we_d;
         mmcm_rst_q <= mmcm_rst_d;
         busy_q     <= busy_d;
         locked_q   <= locked_d;
         err_q      <= err_d;
         abort_q    <= abort_d;
      end
   end

   assign o_busy     = busy_q;
   assign o_mode     = mode_q;
   assign o_err      = err_q;
   assign o_drp_addr = entry_q[38:32];
   assign o_drp_di   = di_q;
   assign o_drp_en   = drp_en_q;
   assign o_drp_we   = drp_we_q;
   assign o_mmcm_rst = mmcm_rst_q;
   assign o_locked   = locked_q;

endmodule
